demux2_stream: RTL
==================

// Module: demux2_stream
// PURPOSE
//   1:2 stream demultiplexer: the routing counterpart of mux2. Each input word
//   is steered to output 0 or 1 by in_sel and held in a one-entry register slot
//   per output, with valid/ready on every side. Used to fan one operand stream
//   out to two consumers, e.g. two ALU lanes.
// PARAMETERS
//   WIDTH  8  data width of in_data / outN_data
//   CNT_W  8  width of the per-output delivered-word counters
// PORTS
//   clk         in   1      clock, all state updates on rising edge
//   rst_n       in   1      asynchronous reset, active low
//   in_data     in   WIDTH  input word
//   in_sel      in   1      destination: 0 -> out0, 1 -> out1; qualified by in_valid
//   in_valid    in   1      input word present
//   in_ready    out  1      demux accepts in_data this cycle
//   out0_data   out  WIDTH  slot 0 word
//   out0_valid  out  1      slot 0 full
//   out0_ready  in   1      consumer 0 takes out0_data
//   out1_data   out  WIDTH  slot 1 word
//   out1_valid  out  1      slot 1 full
//   out1_ready  in   1      consumer 1 takes out1_data
//   cnt0        out  CNT_W  words delivered on out0 (handshakes), wraps
//   cnt1        out  CNT_W  words delivered on out1 (handshakes), wraps
// BEHAVIOUR
//   - Reset (async, rst_n=0): outN_valid=0, outN_data=0, cntN=0. Slot contents
//     are discarded; no word survives reset mid-operation. Release is sampled
//     on the first clk rising edge after deassertion.
//   - Slot FSM per output, two states:
//       EMPTY -> FULL on load.
//       FULL  -> EMPTY on drain without load.
//       FULL  -> FULL  on drain+load (new data) or on stall (data held).
//   - outN_valid = (state==FULL). outN_data is stable while valid && !ready.
//   - Drain: outN_valid && outN_ready.
//   - Load of slot s: in_valid && in_ready && in_sel==s.
//   - in_ready = !outS_valid || outS_ready, with S = in_sel. This path is
//     combinational from in_sel and outS_ready. It is independent of in_valid.
//   - Latency: a word accepted at edge k appears on outS_valid/outS_data after
//     edge k (1 cycle). Throughput is 1 word/cycle per slot when its consumer
//     is always ready.
//   - No head-of-line blocking across slots: a stalled out1 does not block
//     words with in_sel=0.
//   - Order is preserved per output only. No ordering between out0 and out1.
//   - Simultaneous drain and load on the same slot: both occur, valid stays 1,
//     data takes the new word.
//   - A drain on one slot and a load on the other in the same cycle are
//     independent.
//   - cntN increments by 1 on each drain of slot N, modulo 2**CNT_W
//     (2**CNT_W-1 -> 0). cntN does not change on loads.
//   - in_valid=0: no state change except drains. in_sel is don't-care.
// STRUCTURE
//   - Package demux_pkg:
//       typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
//       localparam SEL_OUT0=1'b0, SEL_OUT1=1'b1.
//   - Sub-module stream_slot #(WIDTH, CNT_W): one-entry register with FSM and
//     drain counter, instantiated twice.
//   - Top level holds only the in_sel decode and the in_ready mux.
// TESTING
//   1. Reset: rst_n=0 with slots full -> out0/1_valid=0, data=0, cnt0/1=0
//      immediately, before any clk edge.
//   2. Routing: WIDTH=8, send 8'hA5 sel=0, then 8'h3C sel=1, both consumers
//      ready -> out0=A5 then out1=3C, each 1 cycle after its accept;
//      cnt0=1, cnt1=1.
//   3. Stall isolation: out1_ready=0, send 8'h11 sel=1, then 8'h22 sel=1 ->
//      in_ready=0 for the second word. Then send 8'h33 sel=0 -> accepted and
//      delivered on out0; out1_data holds 11.
//   4. Back-to-back: out0_ready=1, sel=0, words 0..9 on consecutive cycles ->
//      in_ready stays 1, out0 shows 0..9 in order with no bubbles; cnt0=10.
//   5. Wrap: CNT_W=4, 17 drains on out1 -> cnt1 reads 15 after 15 drains,
//      0 after 16, 1 after 17.
//   6. Reset mid-stream: slot0 full with 8'h77, out0_ready=0, pulse rst_n low
//      -> out0_valid=0 and 77 is never delivered.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared slot state encoding and in_sel destination codes
package demux_pkg;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;
endpackage

// File: rtl/stream_slot.sv
// stream_slot: one-entry output register with full/empty FSM and drain counter
module stream_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);
  slot_state_t state, state_nxt;
  logic drain;
  assign valid = state == SLOT_FULL;
  assign drain = valid && ready;
  // a load wins over a drain so drain+load keeps the slot full with the new word
  always_comb state_nxt = load ? SLOT_FULL : drain ? SLOT_EMPTY : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SLOT_EMPTY;
      data  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) data <= load_data;
      if (drain) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: 1:2 stream demultiplexer steering each word to a per-output slot
module demux2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic accept;
  // readiness follows only the addressed slot, so a stalled slot never blocks the other
  assign in_ready = (in_sel == SEL_OUT1) ? (!out1_valid || out1_ready)
                                         : (!out0_valid || out0_ready);
  assign accept = in_valid && in_ready;
  stream_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .load(accept && in_sel == SEL_OUT0), .load_data(in_data),
    .ready(out0_ready), .data(out0_data), .valid(out0_valid), .cnt(cnt0)
  );
  stream_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .load(accept && in_sel == SEL_OUT1), .load_data(in_data),
    .ready(out1_ready), .data(out1_data), .valid(out1_valid), .cnt(cnt1)
  );
endmodule
